seg_scan_decoder: RTL and testbench

- Receiving end of the multiplexed 8-digit seven-segment bus that the BCD counter/display blocks drive.
- Samples seg_com/seg_data, filters scan transitions, and decodes each digit's segment pattern back to BCD.
- Assembles complete frames and reports them with error flags.
- Used for self-checking benches and on-chip loopback monitoring of the display path.

---
 rtl/seg_scan_decoder.sv | 105 ++++++++++
 tb/tb_seg_scan_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: filters the multiplexed 7-segment bus and rebuilds
// BCD frames with code, select and timeout error pulses.
module seg_scan_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [7:0]  seg_com,
  input  logic [7:0]  seg_data,
  output logic [31:0] bcd_out,
  output logic [7:0]  dp_out,
  output logic        frame_valid,
  output logic [15:0] frame_cnt,
  output logic        code_err,
  output logic        com_err,
  output logic        timeout
);
  logic [7:0]  r_com, r_data, r_pcom, r_pdata, r_stab, r_seen, r_dp, r_dpo;
  logic [31:0] r_dig, r_bcd;
  logic [19:0] r_tmr;
  logic [15:0] r_fcnt;
  logic        r_fv, r_cerr, r_merr, r_tmo;
  logic        w_acc, w_idle, w_onehot, w_multi, w_hit, w_bad, w_done, w_tmo, w_same;
  logic [7:0]  w_sel, w_seen_nxt, w_dp_nxt;
  logic [3:0]  w_code;
  logic [31:0] w_bcd_nxt;

  // r_pcom/r_pdata hold the pair that has just met the stability count
  assign w_same     = {r_com, r_data} == {r_pcom, r_pdata};
  assign w_acc      = r_stab == 8'(STABLE_CYC - 1);
  assign w_sel      = ~r_pcom;
  assign w_idle     = &r_pcom;
  assign w_onehot   = $onehot(w_sel);
  assign w_multi    = !w_idle && !w_onehot;
  assign w_hit      = w_acc && !w_idle;
  assign w_seen_nxt = r_seen | w_sel;
  assign w_done     = w_acc && w_onehot && (w_seen_nxt == 8'hFF);
  assign w_tmo      = (|r_seen) && (r_tmr == 20'(TIMEOUT - 1));
  assign w_dp_nxt   = (r_dp & ~w_sel) | (w_sel & {8{r_pdata[0]}});

  always_comb begin
    w_code = 4'hE;
    w_bad  = 1'b0;
    case (r_pdata[7:1])
      7'b1111110: w_code = 4'd0;
      7'b0110000: w_code = 4'd1;
      7'b1101101: w_code = 4'd2;
      7'b1111001: w_code = 4'd3;
      7'b0110011: w_code = 4'd4;
      7'b1011011: w_code = 4'd5;
      7'b1011111: w_code = 4'd6;
      7'b1110000: w_code = 4'd7;
      7'b1111111: w_code = 4'd8;
      7'b1111011: w_code = 4'd9;
      7'b0000000: w_code = 4'hF;
      default:    w_bad  = 1'b1;
    endcase
  end

  always_comb begin
    w_bcd_nxt = r_dig;
    for (int i = 0; i < 8; i++)
      if (w_sel[i]) w_bcd_nxt[4*i +: 4] = w_code;
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      {r_com, r_data, r_pcom, r_pdata, r_stab, r_seen, r_dp, r_dpo} <= '0;
      {r_dig, r_bcd, r_tmr, r_fcnt} <= '0;
      {r_fv, r_cerr, r_merr, r_tmo} <= '0;
    end else begin
      r_com   <= seg_com;
      r_data  <= seg_data;
      r_pcom  <= r_com;
      r_pdata <= r_data;
      r_stab  <= !w_same ? 8'd0 : (r_stab == 8'hFF ? r_stab : r_stab + 8'd1);
      r_fv    <= w_done;
      r_cerr  <= w_acc && w_onehot && w_bad;
      r_merr  <= w_acc && w_multi;
      r_tmo   <= !w_hit && w_tmo;
      r_tmr   <= (w_hit || w_tmo) ? 20'd0 : ((|r_seen) ? r_tmr + 20'd1 : r_tmr);
      if (w_acc && w_onehot) begin
        r_dig  <= w_bcd_nxt;
        r_dp   <= w_dp_nxt;
        r_seen <= w_done ? 8'd0 : w_seen_nxt;
      end else if (!w_hit && w_tmo) begin
        r_seen <= 8'd0;
      end
      if (w_done) begin
        r_bcd  <= w_bcd_nxt;
        r_dpo  <= w_dp_nxt;
        r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign dp_out      = r_dpo;
  assign frame_valid = r_fv;
  assign frame_cnt   = r_fcnt;
  assign code_err    = r_cerr;
  assign com_err     = r_merr;
  assign timeout     = r_tmo;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans of the display bus with hand-computed frames.
module tb_seg_scan_decoder;
  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  seg_com = 8'hFF;
  logic [7:0]  seg_data = 8'h00;
  logic [31:0] bcd_out;
  logic [7:0]  dp_out;
  logic        frame_valid, code_err, com_err, timeout;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_fv = 0, n_ce = 0, n_me = 0, n_to = 0, fv_cyc = 0, to_cyc = 0, c_mark = 0;
  logic [6:0] pat [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  seg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT(64)) dut (
    .mclk(mclk), .rst(rst), .seg_com(seg_com), .seg_data(seg_data),
    .bcd_out(bcd_out), .dp_out(dp_out), .frame_valid(frame_valid),
    .frame_cnt(frame_cnt), .code_err(code_err), .com_err(com_err), .timeout(timeout)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;
  always @(negedge mclk) begin
    if (frame_valid) begin n_fv++; fv_cyc = cyc; end
    if (code_err) n_ce++;
    if (com_err) n_me++;
    if (timeout) begin n_to++; to_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] v);
    return v == 4'hF ? 7'b0000000 : (v == 4'hE ? 7'b1001001 : pat[v]);
  endfunction

  task automatic drive(input logic [7:0] com, input logic [7:0] data, input int n);
    seg_com = com;
    seg_data = data;
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic dig(input int i, input logic [3:0] v, input logic dp, input int n);
    drive(~(8'h01 << i), {enc(v), dp}, n);
  endtask

  task automatic scan(input logic [31:0] vals, input logic [7:0] dps);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) c_mark = cyc;
      dig(i, vals[4*i +: 4], dps[i], 6);
    end
    drive(8'hFF, 8'h00, 4);
  endtask

  initial begin
    repeat (3) begin
      seg_com = 8'($urandom);
      seg_data = 8'($urandom);
      @(posedge mclk);
    end
    #1;
    check("rst_bcd", bcd_out, 32'h0);
    check("rst_pulses", {24'h0, dp_out, 4'h0, frame_valid, code_err, com_err, timeout}, 32'h0);
    check("rst_fcnt", {16'h0, frame_cnt}, 32'h0);
    rst = 1'b1;
    drive(8'hFF, 8'h00, 10);
    check("idle_fv", n_fv, 0);
    check("idle_bcd", bcd_out, 32'h0);

    scan(32'h87654321, 8'h08);
    check("f1_cnt", n_fv, 1);
    check("f1_bcd", bcd_out, 32'h87654321);
    check("f1_dp", {24'h0, dp_out}, 32'h08);
    check("f1_fcnt", {16'h0, frame_cnt}, 32'h1);
    check("f1_latency", fv_cyc - c_mark, 6);
    check("f1_no_err", n_ce + n_me + n_to, 0);

    scan(32'h87F54E21, 8'h00);
    check("f2_code_err", n_ce, 1);
    check("f2_bcd", bcd_out, 32'h87F54E21);
    check("f2_fcnt", {16'h0, frame_cnt}, 32'h2);

    for (int i = 0; i < 4; i++) dig(i, (i == 0) ? 4'd4 : (i == 1) ? 4'd2 : (i == 2) ? 4'd0 : 4'd9, 1'b0, 6);
    drive(8'b11110011, {pat[8], 1'b1}, 6);
    for (int i = 4; i < 8; i++) dig(i, (i == 4) ? 4'd7 : (i == 5) ? 4'd5 : (i == 6) ? 4'd3 : 4'd1, 1'b0, 6);
    drive(8'hFF, 8'h00, 4);
    check("com_err_pulse", n_me, 1);
    check("f3_cnt", n_fv, 3);
    check("f3_bcd", bcd_out, 32'h13579024);
    check("f3_dp", {24'h0, dp_out}, 32'h0);

    dig(0, 4'd6, 1'b1, 3);
    for (int i = 1; i < 8; i++) dig(i, 4'(i), 1'b0, 6);
    drive(8'hFF, 8'h00, 4);
    check("short_no_frame", n_fv, 3);
    dig(0, 4'd0, 1'b1, 6);
    drive(8'hFF, 8'h00, 4);
    check("f4_cnt", n_fv, 4);
    check("f4_bcd", bcd_out, 32'h76543210);
    check("f4_dp", {24'h0, dp_out}, 32'h01);

    for (int i = 0; i < 5; i++) begin
      if (i == 4) c_mark = cyc;
      dig(i, 4'd9, 1'b0, 6);
    end
    drive(8'hFF, 8'h00, 70);
    check("to_cnt", n_to, 1);
    check("to_time", to_cyc - c_mark, 70);
    check("to_no_frame", n_fv, 4);
    scan(32'h24681357, 8'hF0);
    check("f5_cnt", n_fv, 5);
    check("f5_bcd", bcd_out, 32'h24681357);
    check("f5_dp", {24'h0, dp_out}, 32'hF0);
    check("f5_fcnt", {16'h0, frame_cnt}, 32'h5);
    check("f5_to", n_to, 1);

    force dut.r_fcnt = 16'hFFFE;
    @(posedge mclk);
    #1;
    release dut.r_fcnt;
    drive(8'hFF, 8'h00, 2);
    scan(32'h11111111, 8'h00);
    check("wrap_ffff", {16'h0, frame_cnt}, 32'hFFFF);
    scan(32'h99999999, 8'hFF);
    check("wrap_zero", {16'h0, frame_cnt}, 32'h0);
    check("wrap_fv", n_fv, 7);

    for (int i = 0; i < 4; i++) dig(i, 4'd9, 1'b1, 6);
    rst = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    rst = 1'b1;
    check("mid_rst_bcd", bcd_out, 32'h0);
    check("mid_rst_fcnt", {16'h0, frame_cnt}, 32'h0);
    drive(8'hFF, 8'h00, 4);
    for (int i = 4; i < 8; i++) dig(i, 4'(i + 1), 1'b0, 6);
    drive(8'hFF, 8'h00, 4);
    check("mid_rst_nofv", n_fv, 7);
    for (int i = 0; i < 4; i++) dig(i, 4'(i + 1), 1'b0, 6);
    drive(8'hFF, 8'h00, 4);
    check("post_rst_fv", n_fv, 8);
    check("post_rst_bcd", bcd_out, 32'h87654321);
    check("post_rst_dp", {24'h0, dp_out}, 32'h0);
    check("post_rst_fcnt", {16'h0, frame_cnt}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
